motor_drive_decoder: RTL
========================

# motor_drive_decoder

Receiving end of the steering command bus: consumes the 4-bit `DIR` code from the line-sensor direction controller and drives the left and right motor H-bridges. Decodes direction (proceed/left/right/stop) and intensity (full/veer/90-degree) into per-motor PWM duty and rotation sense. Runs timed pivot turns for 90-degree codes and inserts dead time on every motor reversal. Sits between the direction controller and the H-bridge pins.

## Interface
- `PWM_PERIOD`, 1000: PWM period in clk cycles (50 kHz at 50 MHz).
- `DUTY_FULL`, 1000: high cycles per period for full drive.
- `DUTY_VEER`, 500: high cycles for the inner wheel on a veer.
- `DUTY_HARD`, 700: high cycles for both wheels during a pivot.
- `DEAD_TIME`, 50_000: cycles with both PWM low before any direction-bit change.
- `TURN_TIME`, 25_000_000: pivot duration in cycles (500 ms).
- `RAMP_STEP`, 50: duty change per period; soft-start only.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `DIR`, input, 4: `[3:2]` direction (00 proceed, 01 left, 10 right, 11 stop); `[1:0]` intensity (00 full, 01 veer, 11 90-degree). Same clock domain.
- `L_PWM`, `R_PWM`, output, 1: motor enable PWM.
- `L_FWD`, `R_FWD`, output, 1: 1 = forward, 0 = reverse.
- `TURN_BUSY`, output, 1: high while in DEAD or PIVOT.

## Operation
- `DIR` is registered once (`dir_q`). All decoding uses `dir_q`.
- Decode (target duty L/R, target fwd L/R):
  - 0000: FULL/FULL, fwd/fwd.
  - 0101: VEER/FULL, fwd/fwd.
  - 1001: FULL/VEER, fwd/fwd.
  - 0111: pivot left; L reverse, R forward, HARD/HARD.
  - 1011: pivot right; L forward, R reverse, HARD/HARD.
  - 1111 and every other code: 0/0; fwd bits unchanged.
- FSM states:
  - RUN:
    - If the target fwd bits differ from the current fwd bits, go to DEAD.
    - Else, if the code is a pivot code and `armed`, go to PIVOT.
    - Else, apply the target duty.
  - DEAD:
    - PWM is forced low and the counter counts to `DEAD_TIME`.
    - Then the fwd bits update to the latched target.
    - Next state is PIVOT if the latched command was a pivot, else RUN.
  - PIVOT:
    - Counts `TURN_TIME` cycles at HARD/HARD. `dir_q` is ignored.
    - On expiry, clear `armed` and go to RUN.
- `armed`:
  - Set whenever `dir_q` is not a pivot code.
  - While clear, a pivot code decodes as stop (0/0, fwd unchanged).
  - This prevents re-pivoting on a held code.
- PWM:
  - `pwm_cnt` counts 0..`PWM_PERIOD`-1 and wraps.
  - Output = (`pwm_cnt` < `duty`). Duty ≥ `PWM_PERIOD` gives constant high; duty 0 gives constant low.
- The applied duty register loads only at wrap (`pwm_cnt` = `PWM_PERIOD`-1). This keeps pulses glitch-free.
- DEAD forces outputs low immediately, not waiting for wrap.

## Timing
- Reset values: `L_PWM`=`R_PWM`=0, `L_FWD`=`R_FWD`=1, `TURN_BUSY`=0, state RUN, duty 0, `pwm_cnt` 0, `armed`=1, counters 0.
- `DIR` change to FSM decision: 1 cycle (register).
- Duty change reaches the pins at the next PWM wrap, at most `PWM_PERIOD`+1 cycles later.
- `TURN_BUSY` rises the cycle the state leaves RUN and falls the cycle the state returns to RUN.
- The fwd bits change exactly `DEAD_TIME` cycles after DEAD entry. PWM stays low on that cycle and resumes from the next wrap.
- The pivot lasts exactly `TURN_TIME` cycles after DEAD exit.
- A command change during DEAD or PIVOT is not latched. It is re-evaluated in RUN.
- `rst_n` low mid-DEAD or mid-PIVOT gives reset values asynchronously. No dead-time guarantee applies across reset.
- Counter widths are `$clog2` of the respective parameter. No overflow is possible.

## Configuration
- `MOTOR_SOFTSTART_EN`:
  - Defined: at each wrap the applied duty moves toward the target by at most `RAMP_STEP`, clamped at the target. DEAD still forces the applied duty to 0, so ramps restart from 0 after any reversal.
  - Undefined: the applied duty jumps to the target at wrap.

## Test plan
- Release reset with `DIR`=1111 -> all outputs at reset values; PWM low indefinitely.
- `PWM_PERIOD`=100, `DUTY_VEER`=50, `DIR`=0101 -> after the next wrap, `L_PWM` is high 50 of every 100 cycles, `R_PWM` is constant high, and both fwd bits are 1.
- `DEAD_TIME`=20, `TURN_TIME`=1000, `DIR`=0111 -> `TURN_BUSY` goes high and both PWM outputs go low for 20 cycles. Then `L_FWD`=0, and both PWM run at HARD for 1000 cycles. `DIR`=0000 injected mid-pivot has no effect.
- After the pivot with `DIR` held at 0111 -> PWM is 0 and there is no second pivot. Setting `DIR`=0000 -> 20 dead cycles, then `L_FWD`=1 and FULL on both.
- Pulse `rst_n` low mid-pivot -> outputs take reset values within the same cycle; state is RUN after release.
- `DIR`=0010 (undefined code) -> stop, duty 0, fwd bits unchanged. With `MOTOR_SOFTSTART_EN` and 0000 from stop, duty rises 0, 50, 100, ... per period to FULL.

Source files
------------

// File: rtl/motor_drive_decoder.sv
// motor_drive_decoder: decodes DIR steering codes into left/right H-bridge PWM, rotation sense and timed pivots.
// Latency: DIR registered once, FSM decides the next cycle; duty reaches the pins at the next PWM wrap.
// Backpressure: none; DIR is sampled every cycle and is ignored (not latched) while TURN_BUSY is high.
// Optional soft-start ramp: define MOTOR_SOFTSTART_EN.
module motor_drive_decoder #(
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_FULL  = 1000,
  parameter int DUTY_VEER  = 500,
  parameter int DUTY_HARD  = 700,
  parameter int DEAD_TIME  = 50_000,
  parameter int TURN_TIME  = 25_000_000,
  parameter int RAMP_STEP  = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] DIR,
  output logic       L_PWM,
  output logic       R_PWM,
  output logic       L_FWD,
  output logic       R_FWD,
  output logic       TURN_BUSY
);

  // Duty registers must hold the largest duty or the period, whichever is bigger,
  // so that "duty >= period" stays representable and means constant high.
  localparam int DMAX0 = (DUTY_FULL > DUTY_VEER) ? DUTY_FULL : DUTY_VEER;
  localparam int DMAX1 = (DMAX0 > DUTY_HARD) ? DMAX0 : DUTY_HARD;
  localparam int DMAXP = (DMAX1 > PWM_PERIOD) ? DMAX1 : PWM_PERIOD;
  localparam int DW    = $clog2(DMAXP + 1);
  localparam int PW    = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int TWD   = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam int TWT   = (TURN_TIME > 1) ? $clog2(TURN_TIME) : 1;

  localparam logic [DW-1:0]  C_FULL      = DW'(DUTY_FULL);
  localparam logic [DW-1:0]  C_VEER      = DW'(DUTY_VEER);
  localparam logic [DW-1:0]  C_HARD      = DW'(DUTY_HARD);
  localparam logic [PW-1:0]  C_PWM_LAST  = PW'(PWM_PERIOD - 1);
  localparam logic [TWD-1:0] C_DEAD_LAST = TWD'(DEAD_TIME - 1);
  localparam logic [TWT-1:0] C_TURN_LAST = TWT'(TURN_TIME - 1);

  // Largest duty change allowed per wrap. Without soft-start the step spans the
  // full duty range, so the applied duty lands on its goal at the first wrap.
`ifdef MOTOR_SOFTSTART_EN
  localparam int STEP_EFF = (RAMP_STEP > 0) ? RAMP_STEP : 1;
`else
  localparam int STEP_EFF = (RAMP_STEP > DMAXP) ? RAMP_STEP : DMAXP;
`endif

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DEAD  = 2'd1;
  localparam logic [1:0] S_PIVOT = 2'd2;

  logic [3:0]     r_dir_q;
  logic [1:0]     r_state;
  logic           r_fwd_l;
  logic           r_fwd_r;
  logic           r_lat_fwd_l;
  logic           r_lat_fwd_r;
  logic           r_lat_piv;
  logic           r_armed;
  logic [TWD-1:0] r_dead_cnt;
  logic [TWT-1:0] r_turn_cnt;
  logic [PW-1:0]  r_pwm_cnt;
  logic [DW-1:0]  r_duty_l;
  logic [DW-1:0]  r_duty_r;

  logic [DW-1:0]  w_tgt_duty_l;
  logic [DW-1:0]  w_tgt_duty_r;
  logic           w_tgt_fwd_l;
  logic           w_tgt_fwd_r;
  logic           w_tgt_piv;
  logic           w_is_pivot_code;
  logic           w_fwd_diff;
  logic           w_enter_dead;
  logic           w_pivot_done;
  logic           w_wrap;
  logic [DW-1:0]  w_goal_l;
  logic [DW-1:0]  w_goal_r;

  // Moves the applied duty toward its goal by at most STEP_EFF, never overshooting.
  function automatic logic [DW-1:0] f_duty_step(input logic [DW-1:0] cur,
                                                input logic [DW-1:0] goal);
    int c;
    int g;
    int n;
    c = int'(cur);
    g = int'(goal);
    if (c < g) begin
      n = ((g - c) > STEP_EFF) ? (c + STEP_EFF) : g;
    end else if (c > g) begin
      n = ((c - g) > STEP_EFF) ? (c - STEP_EFF) : g;
    end else begin
      n = g;
    end
    return DW'(n);
  endfunction

  // Single input register; every decision below works from r_dir_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir_q <= 4'b1111;
    end else begin
      r_dir_q <= DIR;
    end
  end

  // Decode the registered code into target duty, target rotation sense and pivot request.
  // A pivot code seen while disarmed behaves exactly like stop.
  always_comb begin
    w_tgt_duty_l    = '0;
    w_tgt_duty_r    = '0;
    w_tgt_fwd_l     = r_fwd_l;
    w_tgt_fwd_r     = r_fwd_r;
    w_tgt_piv       = 1'b0;
    w_is_pivot_code = (r_dir_q == 4'b0111) || (r_dir_q == 4'b1011);
    case (r_dir_q)
      4'b0000: begin
        w_tgt_duty_l = C_FULL;
        w_tgt_duty_r = C_FULL;
        w_tgt_fwd_l  = 1'b1;
        w_tgt_fwd_r  = 1'b1;
      end
      4'b0101: begin
        w_tgt_duty_l = C_VEER;
        w_tgt_duty_r = C_FULL;
        w_tgt_fwd_l  = 1'b1;
        w_tgt_fwd_r  = 1'b1;
      end
      4'b1001: begin
        w_tgt_duty_l = C_FULL;
        w_tgt_duty_r = C_VEER;
        w_tgt_fwd_l  = 1'b1;
        w_tgt_fwd_r  = 1'b1;
      end
      4'b0111: begin
        if (r_armed) begin
          w_tgt_duty_l = C_HARD;
          w_tgt_duty_r = C_HARD;
          w_tgt_fwd_l  = 1'b0;
          w_tgt_fwd_r  = 1'b1;
          w_tgt_piv    = 1'b1;
        end
      end
      4'b1011: begin
        if (r_armed) begin
          w_tgt_duty_l = C_HARD;
          w_tgt_duty_r = C_HARD;
          w_tgt_fwd_l  = 1'b1;
          w_tgt_fwd_r  = 1'b0;
          w_tgt_piv    = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Transition qualifiers shared by the FSM, arming and duty logic.
  always_comb begin
    w_fwd_diff   = (w_tgt_fwd_l != r_fwd_l) || (w_tgt_fwd_r != r_fwd_r);
    w_enter_dead = (r_state == S_RUN) && w_fwd_diff;
    w_pivot_done = (r_state == S_PIVOT) && (r_turn_cnt == C_TURN_LAST);
    w_wrap       = (r_pwm_cnt == C_PWM_LAST);
    // During a pivot the command is ignored and both wheels run HARD.
    w_goal_l     = (r_state == S_PIVOT) ? C_HARD : w_tgt_duty_l;
    w_goal_r     = (r_state == S_PIVOT) ? C_HARD : w_tgt_duty_r;
  end

  // Steering FSM: dead time before any reversal, then optional timed pivot.
  // Commands arriving during DEAD or PIVOT are only looked at again once back in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_fwd_l     <= 1'b1;
      r_fwd_r     <= 1'b1;
      r_lat_fwd_l <= 1'b1;
      r_lat_fwd_r <= 1'b1;
      r_lat_piv   <= 1'b0;
      r_dead_cnt  <= '0;
      r_turn_cnt  <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_fwd_diff) begin
            r_state     <= S_DEAD;
            r_lat_fwd_l <= w_tgt_fwd_l;
            r_lat_fwd_r <= w_tgt_fwd_r;
            r_lat_piv   <= w_tgt_piv;
            r_dead_cnt  <= '0;
          end else if (w_tgt_piv) begin
            r_state    <= S_PIVOT;
            r_turn_cnt <= '0;
          end
        end
        S_DEAD: begin
          if (r_dead_cnt == C_DEAD_LAST) begin
            r_fwd_l    <= r_lat_fwd_l;
            r_fwd_r    <= r_lat_fwd_r;
            r_dead_cnt <= '0;
            if (r_lat_piv) begin
              r_state    <= S_PIVOT;
              r_turn_cnt <= '0;
            end else begin
              r_state <= S_RUN;
            end
          end else begin
            r_dead_cnt <= r_dead_cnt + 1'b1;
          end
        end
        S_PIVOT: begin
          if (r_turn_cnt == C_TURN_LAST) begin
            r_state    <= S_RUN;
            r_turn_cnt <= '0;
          end else begin
            r_turn_cnt <= r_turn_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  // Arming: a completed pivot disarms; any non-pivot code re-arms, so a held
  // pivot code cannot trigger a second turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b1;
    end else if (w_pivot_done) begin
      r_armed <= 1'b0;
    end else if (!w_is_pivot_code) begin
      r_armed <= 1'b1;
    end
  end

  // Free-running PWM period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
    end else if (w_wrap) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  // Applied duty: zeroed at once on dead-time entry and held there through DEAD,
  // otherwise updated only at wrap so a pulse is never cut or stretched mid-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_l <= '0;
      r_duty_r <= '0;
    end else if (w_enter_dead || (r_state == S_DEAD)) begin
      r_duty_l <= '0;
      r_duty_r <= '0;
    end else if (w_wrap) begin
      r_duty_l <= f_duty_step(r_duty_l, w_goal_l);
      r_duty_r <= f_duty_step(r_duty_r, w_goal_r);
    end
  end

  // Pin drive: PWM compare gated off throughout DEAD.
  always_comb begin
    L_PWM     = (r_state != S_DEAD) && (DW'(r_pwm_cnt) < r_duty_l);
    R_PWM     = (r_state != S_DEAD) && (DW'(r_pwm_cnt) < r_duty_r);
    L_FWD     = r_fwd_l;
    R_FWD     = r_fwd_r;
    TURN_BUSY = (r_state != S_RUN);
  end

endmodule
